// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package seg_pkg;

    localparam int SEG_MAX_DIGITS = 8;
    localparam int SEG_IDX_W      = $clog2(SEG_MAX_DIGITS);

    // Single anode "off" bit; callers replicate it to the instance digit count.
    localparam logic AN_OFF = 1'b1;

    typedef struct packed {
        logic [3:0] hex;
        logic       point;
        logic       le;
    } seg_digit_t;

    function automatic logic [SEG_MAX_DIGITS-1:0] seg_an_onehot(
        input logic [SEG_IDX_W-1:0] idx,
        input int                   digits
    );
        logic [SEG_MAX_DIGITS-1:0] an;
        an = {SEG_MAX_DIGITS{AN_OFF}};
        if (int'(idx) < digits) an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seg_scan_div.sv
// Slot divider and digit scan counter. Exposes next-state scan and dead-time
// so the parent can register its outputs for the coming cycle.
module seg_scan_div #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2,
    parameter int SW       = $clog2(DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [SW-1:0] scan,
    output logic [SW-1:0] scan_nxt,
    output logic          slot_start,
    output logic          wrap,
    output logic          dead
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          primed;
    logic          tc;

    assign tc         = (div_cnt == DW'(SCAN_DIV - 1));
    assign slot_start = en & tc;
    // Until the first terminal count after reset, treat the slot end as a
    // frame wrap so the first real frame begins with a fresh snapshot.
    assign wrap       = slot_start & (~primed | (scan == SW'(DIGITS - 1)));

    always_comb begin
        div_nxt  = div_cnt;
        scan_nxt = scan;
        if (slot_start) begin
            div_nxt  = '0;
            scan_nxt = wrap ? '0 : scan + 1'b1;
        end else if (en) begin
            div_nxt  = div_cnt + 1'b1;
        end
    end

    assign dead = int'(div_nxt) < DEAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            scan    <= '0;
            primed  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            scan    <= scan_nxt;
            primed  <= primed | slot_start;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver with per-frame snapshot,
// dead-time, PWM brightness and per-digit enable. Leading-zero blanking is
// built only when SEG_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int  DIGITS   = 8,
    parameter int  SCAN_DIV = 50000,
    parameter int  DEAD     = 2,
    localparam int SW       = $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*DIGITS-1:0] hexs,
    input  logic [DIGITS-1:0]   points,
    input  logic [DIGITS-1:0]   LEs,
    input  logic [3:0]          brightness,
    output logic [3:0]          HEX,
    output logic                point,
    output logic                LE,
    output logic [DIGITS-1:0]   AN,
    output logic [SW-1:0]       scan,
    output logic                frame_tick
);

    logic [SW-1:0] scan_nxt;
    logic          slot_start;
    logic          wrap;
    logic          dead;

    seg_scan_div #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .DEAD    (DEAD),
        .SW      (SW)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scan      (scan),
        .scan_nxt  (scan_nxt),
        .slot_start(slot_start),
        .wrap      (wrap),
        .dead      (dead)
    );

    logic [4*DIGITS-1:0] snap_hex;
    logic [DIGITS-1:0]   snap_pt;
    logic [DIGITS-1:0]   snap_le;

    // Data as it will be after this edge: live inputs on a wrap, else snapshot.
    logic [4*DIGITS-1:0] hex_src;
    logic [DIGITS-1:0]   pt_src;
    logic [DIGITS-1:0]   le_src;
    logic [DIGITS-1:0]   blank;

    assign hex_src = wrap ? hexs   : snap_hex;
    assign pt_src  = wrap ? points : snap_pt;
    assign le_src  = wrap ? LEs    : snap_le;

`ifdef SEG_LZB_EN
    always_comb begin : lzb_blank
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (hex_src[4*i +: 4] == 4'd0);
            blank[i]   = zero_above & ~pt_src[i];
        end
    end
`else
    assign blank = '0;
`endif

    logic [3:0] pwm_cnt;
    logic [3:0] pwm_nxt;
    logic       pwm_on;

    assign pwm_nxt = en ? pwm_cnt + 4'd1 : pwm_cnt;
    assign pwm_on  = (brightness == 4'hF) | (pwm_nxt < brightness);

    logic                      an_on;
    logic [SEG_MAX_DIGITS-1:0] an_hot;
    logic                      unused_an;
    seg_digit_t                nxt_digit;
    seg_digit_t                cur_digit;

    assign an_on     = en & ~dead & le_src[scan_nxt] & ~blank[scan_nxt] & pwm_on;
    assign an_hot    = seg_an_onehot(SEG_IDX_W'(scan_nxt), DIGITS);
    assign unused_an = ^an_hot;

    assign nxt_digit.hex   = hex_src[{scan_nxt, 2'b00} +: 4];
    assign nxt_digit.point = pt_src[scan_nxt];
    assign nxt_digit.le    = le_src[scan_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_hex   <= '0;
            snap_pt    <= '0;
            snap_le    <= '0;
            pwm_cnt    <= '0;
            cur_digit  <= '0;
            AN         <= {DIGITS{AN_OFF}};
            frame_tick <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_nxt;
            frame_tick <= wrap;
            if (wrap) begin
                snap_hex <= hexs;
                snap_pt  <= points;
                snap_le  <= LEs;
            end
            if (slot_start) cur_digit <= nxt_digit;
            AN <= an_on ? an_hot[DIGITS-1:0] : {DIGITS{AN_OFF}};
        end
    end

    assign HEX   = cur_digit.hex;
    assign point = cur_digit.point;
    assign LE    = cur_digit.le;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised time-multiplexed driver for common-anode 7-segment digit banks. Replaces the fixed 4-digit, externally scanned selector with an internal scan counter, a per-frame input snapshot, anode dead-time, 4-bit PWM brightness and per-digit enables. Sits between display-data producers and the hex-to-segment decoder. The decoder consumes `HEX`/`point`; the board pins take `AN` directly.

## Interface
Parameters:
- `DIGITS`, default 8: number of digits; legal range 2..8.
- `SCAN_DIV`, default 50000: `clk` cycles per digit slot; must be greater than `DEAD`.
- `DEAD`, default 2: blanking cycles at the start of each slot.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: scan enable.
- `hexs` in 4*DIGITS: nibble i is digit i; digit 0 is least significant.
- `points` in DIGITS: per-digit decimal point, 1 = lit.
- `LEs` in DIGITS: per-digit enable, 1 = digit may light.
- `brightness` in 4: PWM duty; 0 = dark, 15 = full.
- `HEX` out 4: nibble for the active digit.
- `point` out 1: DP for the active digit.
- `LE` out 1: `LEs` bit for the active digit.
- `AN` out DIGITS: anodes, active-low, one-hot-low.
- `scan` out $clog2(DIGITS): active digit index.
- `frame_tick` out 1: one-cycle pulse at the start of each frame.

## Operation
- **Divider.** `div_cnt` counts 0..SCAN_DIV-1 while `en`=1. At terminal count it wraps to 0 and `scan` advances; `scan` wraps from DIGITS-1 to 0.
- **Snapshot.**
  - When `scan` wraps to 0, the live `hexs`/`points`/`LEs` are captured in the same edge. All slots of that frame use the captured values, so a frame never mixes old and new data.
  - `frame_tick`=1 in the cycle after that edge.
- **Registered outputs.** `HEX`, `point` and `LE` are registered. They load the data for the new `scan` value on the same edge that `scan` advances.
- **Anode.** `AN[scan]`=0 only when all of the following hold:
  - `en`=1;
  - `div_cnt` ≥ DEAD;
  - snapshot `LEs[scan]`=1;
  - the digit is not blanked by LZB;
  - the PWM term is true.

  Every other `AN` bit is 1 at all times.
- **PWM.** A free-running 4-bit `pwm_cnt` increments every cycle while `en`=1. The PWM term is true when `brightness`==15 or `pwm_cnt` < `brightness`. `brightness` is sampled live, not snapshotted.
- **`en`=0.** `div_cnt`, `scan`, `pwm_cnt` and the snapshot hold. `AN` goes all-ones on the next edge. `HEX`/`point`/`LE` hold. When `en` returns to 1, scanning resumes from the held position.
- **Reset (asynchronous, any time including mid-slot).** All of the following take their reset values immediately; the first frame starts with a snapshot on the first terminal count after release:
  - `div_cnt`=0, `scan`=0, `pwm_cnt`=0, snapshot=0;
  - `HEX`=0, `point`=0, `LE`=0, `AN`=all-ones, `frame_tick`=0.

## Timing
- **Slot.** Exactly SCAN_DIV cycles. Frame = DIGITS × SCAN_DIV cycles. `frame_tick` period = DIGITS × SCAN_DIV.
- **Dead time.** The first DEAD cycles of every slot have `AN` all-ones, counting from the edge that advanced `scan`.
- **Latency, `hexs` to display.** A `hexs` change is visible no earlier than the next frame start. Worst case is one full frame plus 1 cycle.
- **Latency, `brightness`.** Takes effect on `AN` one cycle after it changes.
- **`en` falling on a terminal-count cycle.** Scan does not advance, because `en` gates the count.
- **Simultaneous wrap and `en`=1.** Snapshot and `frame_tick` both occur.

## Configuration
- **Macro: `SEG_LZB_EN`** (leading-zero blanking).
- **Defined.**
  - Digit i, for i>0, is blanked when its snapshot nibble and every more-significant snapshot nibble are 0, and its snapshot point is 0.
  - Blanking is decided on the snapshot, once per frame. Digit 0 is never blanked.
- **Undefined.** No blanking logic is built; all digits display their nibble, including 0.

## Structure
- **Package `seg_pkg`:**
  - `SEG_MAX_DIGITS`=8;
  - `AN_OFF` (all-ones constant, sized per instance via replication);
  - function `seg_an_onehot(idx, DIGITS)` returning the active-low one-hot anode vector.
- **Sub-module `seg_scan_div`:** holds `div_cnt` plus the `scan` counter. It outputs `scan`, a slot-start strobe, the wrap strobe and the dead-time flag. `seg_scan_ctrl` holds the snapshot, PWM, LZB and output registers.

## Test plan
- **Reset and first frame.** DIGITS=4, SCAN_DIV=8, DEAD=2, `brightness`=15, `LEs`=4'hF, `hexs`=16'h1234, `en`=1. Required: `AN` sequence 1110,1101,1011,0111, each low for 6 of 8 cycles; `HEX`=4,3,2,1; `frame_tick` every 32 cycles.
- **Tear-free update.** Change `hexs` to 16'hABCD mid-frame. Required: the current frame finishes with 1234; the next frame shows D,C,B,A.
- **PWM duty.** `brightness`=4 with SCAN_DIV=64. Required: the active anode is low for 4 of every 16 cycles after dead time. `brightness`=0 → `AN` stays all-ones.
- **Enable and reset.**
  - Drop `en` for 20 cycles mid-slot. Required: `AN` all-ones; `scan` holds; resume continues the same slot count.
  - Assert `rst_n`=0 mid-slot. Required: immediate reset values.
- **LZB.** `SEG_LZB_EN` defined, `hexs`=16'h0050, `points`=0. Required: digits 3 and 2 stay dark; digits 1 and 0 light. Set `points`[3]=1 → digit 3 lights showing 0. Macro undefined → all four digits light.
- **Per-digit enable.** `LEs`=4'b0101. Required: only `AN[0]` and `AN[2]` ever go low; `LE` output tracks 1,0,1,0.
